apple_iie_timing_generator: RTL and testbench
=============================================

Name: apple_iie_timing_generator

Overview:
- Master timing sequencer for the IIe RAM and address-mux datapath.
- Divides the 14.318 MHz master clock into the CPU/video cycle.
- Generates the phase clocks the memory management unit consumes (clk_phi_0, clk_q3) and the DRAM strobes pras_n, pcas_n and ax.
- Shares RAM between video (phi1 half) and CPU (phi0 half), and runs the horizontal/vertical scan counters with blanking and sync.

Parameters:
- H_STATES, 65, CPU cycles per scan line; the last one is the long cycle.
- V_LINES, 262, scan lines per frame (312 for PAL builds).
- VBL_START, 192, first vertically blanked line.
- VSYNC_START, 224, first line of vertical sync (4 lines long).

Ports:
- clk_14m  in  1  14.318 MHz master clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clk_phi_0  out  1  CPU phase 0; high = CPU RAM access half.
- clk_q3  out  1  asymmetric 2 MHz strobe.
- pras_n  out  1  DRAM row address strobe, active low.
- pcas_n  out  1  DRAM column address strobe, active low.
- ax  out  1  address mux select; 1 = row address, 0 = column address.
- video_phase  out  1  high while video owns RAM (phi1 half).
- cycle_end  out  1  one-clk pulse during the final tick of each CPU cycle.
- long_cycle  out  1  high for the whole stretched cycle.
- h_count  out  7  horizontal count, 0..H_STATES-1.
- v_count  out  9  vertical count, 0..V_LINES-1.
- hblank  out  1  high when h_count < 25.
- hsync  out  1  high when 49 <= h_count <= 52.
- vblank  out  1  high when v_count >= VBL_START.
- vsync  out  1  high when VSYNC_START <= v_count < VSYNC_START+4.

Behaviour:
- Tick counter t (4 bits) counts clk_14m edges within a CPU cycle.
  - Normal cycle: t = 0..13.
  - Long cycle (h_count == H_STATES-1): t = 0..15. phi0-high half is stretched by 2 ticks.
- All outputs are registered. The values below hold for the clk_14m period in which t has that value. Decode from next-state so there is no extra lag.
- Phase and strobe waveforms:
  - clk_phi_0 = 1 for t 7..13 (long: 7..15); 0 otherwise.
  - video_phase = ~clk_phi_0.
  - clk_q3 = 1 for t 0..3 and 7..10; 0 otherwise, including t 14..15.
  - ax = 1 for t 0..3 and 7..10; 0 otherwise.
  - pras_n = 0 for t 2..6 and 9..13 (long: 9..15); 1 otherwise.
  - pcas_n = 0 for t 4..6 and 11..13 (long: 11..15); 1 otherwise.
  - Invariant: pcas_n low implies pras_n low and ax = 0.
- Cycle markers:
  - cycle_end = 1 only at t 13 (normal) or t 15 (long).
  - long_cycle = 1 for all ticks of a cycle whose h_count == H_STATES-1.
- Scan counters:
  - On the clock edge ending a cycle (t at its last value), h_count increments. It wraps from H_STATES-1 to 0.
  - On that wrap, v_count increments. It wraps from V_LINES-1 to 0.
  - h_count and v_count change together on the same edge as t returns to 0.
- hblank, hsync, vblank and vsync are decoded combinationally from the next counter values, then registered. They align with h_count and v_count.
- Reset:
  - Reset values: t = 0, h_count = 0, v_count = 0, clk_phi_0 = 0, video_phase = 1, clk_q3 = 1, ax = 1, pras_n = 1, pcas_n = 1, cycle_end = 0, long_cycle = 0, hblank = 1, hsync = 0, vblank = 0, vsync = 0.
  - Assertion takes effect immediately, asynchronously, mid-cycle included. No partial strobe may persist.
  - After release, the first rising edge moves t to 1.
- Widths: H_STATES must be 2..128 and V_LINES must be 2..512. Counter compares use these exact widths with no truncation.

Test Plan:
- Reset release, 14 edges with h_count = 0 -> clk_phi_0 rises at t 7 and falls at t 0 of the next cycle; cycle_end pulses once at t 13; h_count goes 0->1.
- Run to h_count = 64 -> long_cycle = 1; clk_phi_0 high 9 ticks; pras_n low 9..15; the next cycle starts at t 0 with h_count = 0 and v_count +1.
- Run 65*262 cycles -> v_count wraps 261->0 simultaneously with h_count 64->0; vblank high on lines 192..261; vsync high on lines 224..227 only.
- Check every tick over one full line -> pcas_n low never occurs with pras_n high or ax = 1; clk_q3 is low at t 14..15 of the long cycle.
- Assert reset_n at t 11 of a cycle -> pcas_n and pras_n go to 1 at once, without waiting for a clock; h_count and v_count go to 0; clean restart after release.
- Override V_LINES = 312 -> v_count reaches 311 and then wraps to 0.

Source files
------------

// File: rtl/apple_iie_timing_generator.sv
// rtl/apple_iie_timing_generator.sv - IIe master timing: phase clocks, DRAM strobes, scan counters
module apple_iie_timing_generator #(
    parameter int H_STATES    = 65,
    parameter int V_LINES     = 262,
    parameter int VBL_START   = 192,
    parameter int VSYNC_START = 224
) (
    input  logic       clk_14m,
    input  logic       reset_n,
    output logic       clk_phi_0,
    output logic       clk_q3,
    output logic       pras_n,
    output logic       pcas_n,
    output logic       ax,
    output logic       video_phase,
    output logic       cycle_end,
    output logic       long_cycle,
    output logic [6:0] h_count,
    output logic [8:0] v_count,
    output logic       hblank,
    output logic       hsync,
    output logic       vblank,
    output logic       vsync
);

    localparam logic [6:0] H_LAST = 7'(H_STATES - 1);
    localparam logic [8:0] V_LAST = 9'(V_LINES - 1);
    localparam logic [9:0] VBL_LO = 10'(VBL_START);
    localparam logic [9:0] VS_LO  = 10'(VSYNC_START);
    localparam logic [9:0] VS_HI  = 10'(VSYNC_START + 4);

    logic [3:0] t;
    logic [3:0] t_nx;
    logic [6:0] h_nx;
    logic [8:0] v_nx;
    logic       long_now;
    logic       cyc_done;
    logic       long_nx;
    logic       phi0_nx;
    logic       q3_nx;
    logic       ras_n_nx;
    logic       cas_n_nx;
    logic       end_nx;
    logic       hblank_nx;
    logic       hsync_nx;
    logic       vblank_nx;
    logic       vsync_nx;

    // Every output is decoded from the next tick/counter values so registers line up with t.
    always_comb begin
        long_now  = (h_count == H_LAST);
        cyc_done  = (t == (long_now ? 4'd15 : 4'd13));
        t_nx      = cyc_done ? 4'd0 : t + 4'd1;
        h_nx      = h_count;
        v_nx      = v_count;
        if (cyc_done) begin
            if (long_now) begin
                h_nx = 7'd0;
                v_nx = (v_count == V_LAST) ? 9'd0 : v_count + 9'd1;
            end else begin
                h_nx = h_count + 7'd1;
            end
        end
        long_nx   = (h_nx == H_LAST);
        // The stretched ticks 14..15 only exist in the long cycle and extend the phi0 half.
        phi0_nx   = (t_nx >= 4'd7);
        q3_nx     = (t_nx <= 4'd3) || ((t_nx >= 4'd7) && (t_nx <= 4'd10));
        ras_n_nx  = !(((t_nx >= 4'd2) && (t_nx <= 4'd6)) || (t_nx >= 4'd9));
        cas_n_nx  = !(((t_nx >= 4'd4) && (t_nx <= 4'd6)) || (t_nx >= 4'd11));
        end_nx    = (t_nx == (long_nx ? 4'd15 : 4'd13));
        hblank_nx = (h_nx < 7'd25);
        hsync_nx  = (h_nx >= 7'd49) && (h_nx <= 7'd52);
        vblank_nx = ({1'b0, v_nx} >= VBL_LO);
        vsync_nx  = ({1'b0, v_nx} >= VS_LO) && ({1'b0, v_nx} < VS_HI);
    end

    always_ff @(posedge clk_14m or negedge reset_n) begin
        if (!reset_n) begin
            t           <= 4'd0;
            h_count     <= 7'd0;
            v_count     <= 9'd0;
            clk_phi_0   <= 1'b0;
            video_phase <= 1'b1;
            clk_q3      <= 1'b1;
            ax          <= 1'b1;
            pras_n      <= 1'b1;
            pcas_n      <= 1'b1;
            cycle_end   <= 1'b0;
            long_cycle  <= 1'b0;
            hblank      <= 1'b1;
            hsync       <= 1'b0;
            vblank      <= 1'b0;
            vsync       <= 1'b0;
        end else begin
            t           <= t_nx;
            h_count     <= h_nx;
            v_count     <= v_nx;
            clk_phi_0   <= phi0_nx;
            video_phase <= !phi0_nx;
            clk_q3      <= q3_nx;
            ax          <= q3_nx;
            pras_n      <= ras_n_nx;
            pcas_n      <= cas_n_nx;
            cycle_end   <= end_nx;
            long_cycle  <= long_nx;
            hblank      <= hblank_nx;
            hsync       <= hsync_nx;
            vblank      <= vblank_nx;
            vsync       <= vsync_nx;
        end
    end

endmodule

// File: tb/tb_apple_iie_timing_generator.sv
// tb/tb_apple_iie_timing_generator.sv - directed bench for apple_iie_timing_generator
module tb_apple_iie_timing_generator;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Waveform tables: bit n = value at tick n
    localparam logic [15:0] PHI_N   = 16'h3F80;
    localparam logic [15:0] PHI_L   = 16'hFF80;
    localparam logic [15:0] Q3_TAB  = 16'h078F;
    localparam logic [15:0] RASL_N  = 16'h3E7C;
    localparam logic [15:0] RASL_L  = 16'hFE7C;
    localparam logic [15:0] CASL_N  = 16'h3870;
    localparam logic [15:0] CASL_L  = 16'hF870;

    int total = 0;
    int bad = 0;
    int mt[3];
    int mh[3];
    int mv[3];
    int hs[3] = '{65, 2, 2};
    int vl[3] = '{262, 262, 312};

    logic a_phi0, a_q3, a_ras, a_cas, a_ax, a_vp, a_end, a_long, a_hbl, a_hs, a_vbl, a_vs;
    logic [6:0] a_h;
    logic [8:0] a_v;
    logic b_phi0, b_q3, b_ras, b_cas, b_ax, b_vp, b_end, b_long, b_hbl, b_hs, b_vbl, b_vs;
    logic [6:0] b_h;
    logic [8:0] b_v;
    logic c_phi0, c_q3, c_ras, c_cas, c_ax, c_vp, c_end, c_long, c_hbl, c_hs, c_vbl, c_vs;
    logic [6:0] c_h;
    logic [8:0] c_v;
    logic [11:0] a_sig;
    assign a_sig = {a_phi0, a_vp, a_q3, a_ax, a_ras, a_cas, a_end, a_long, a_hbl, a_hs, a_vbl, a_vs};

    apple_iie_timing_generator dut_a (
        .clk_14m(clk), .reset_n(reset_n), .clk_phi_0(a_phi0), .clk_q3(a_q3),
        .pras_n(a_ras), .pcas_n(a_cas), .ax(a_ax), .video_phase(a_vp),
        .cycle_end(a_end), .long_cycle(a_long), .h_count(a_h), .v_count(a_v),
        .hblank(a_hbl), .hsync(a_hs), .vblank(a_vbl), .vsync(a_vs));

    apple_iie_timing_generator #(.H_STATES(2)) dut_b (
        .clk_14m(clk), .reset_n(reset_n), .clk_phi_0(b_phi0), .clk_q3(b_q3),
        .pras_n(b_ras), .pcas_n(b_cas), .ax(b_ax), .video_phase(b_vp),
        .cycle_end(b_end), .long_cycle(b_long), .h_count(b_h), .v_count(b_v),
        .hblank(b_hbl), .hsync(b_hs), .vblank(b_vbl), .vsync(b_vs));

    apple_iie_timing_generator #(.H_STATES(2), .V_LINES(312)) dut_c (
        .clk_14m(clk), .reset_n(reset_n), .clk_phi_0(c_phi0), .clk_q3(c_q3),
        .pras_n(c_ras), .pcas_n(c_cas), .ax(c_ax), .video_phase(c_vp),
        .cycle_end(c_end), .long_cycle(c_long), .h_count(c_h), .v_count(c_v),
        .hblank(c_hbl), .hsync(c_hs), .vblank(c_vbl), .vsync(c_vs));

    function automatic logic [11:0] exp_a(input int t, input int h, input int v);
        logic lg;
        logic [15:0] phi_m, q3_m, ras_m, cas_m;
        lg    = (h == 64);
        phi_m = lg ? PHI_L : PHI_N;
        q3_m  = Q3_TAB;
        ras_m = lg ? RASL_L : RASL_N;
        cas_m = lg ? CASL_L : CASL_N;
        return {phi_m[t], !phi_m[t], q3_m[t], q3_m[t], !ras_m[t], !cas_m[t],
                (t == (lg ? 15 : 13)), lg, (h < 25), (h >= 49 && h <= 52),
                (v >= 192), (v >= 224 && v <= 227)};
    endfunction

    task automatic models_reset();
        for (int i = 0; i < 3; i++) begin
            mt[i] = 0; mh[i] = 0; mv[i] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) begin
            for (int i = 0; i < 3; i++) begin
                if (mt[i] == ((mh[i] == hs[i] - 1) ? 15 : 13)) begin
                    mt[i] = 0;
                    if (mh[i] == hs[i] - 1) begin
                        mh[i] = 0;
                        mv[i] = (mv[i] == vl[i] - 1) ? 0 : mv[i] + 1;
                    end else begin
                        mh[i] = mh[i] + 1;
                    end
                end else begin
                    mt[i] = mt[i] + 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        models_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (a_sig !== 12'h7C8) begin
            bad++; $display("FAIL reset_outputs got=%h want=7c8", a_sig);
        end
        total++;
        if (a_h !== 7'd0 || a_v !== 9'd0) begin
            bad++; $display("FAIL reset_counts got h=%0d v=%0d want 0 0", a_h, a_v);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_first_cycle();
        int ends = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            total++;
            if (a_sig !== exp_a(mt[0], mh[0], mv[0])) begin
                bad++; $display("FAIL first_cycle tick=%0d got=%h want=%h", mt[0], a_sig, exp_a(mt[0], mh[0], mv[0]));
            end
            if (a_end) ends++;
        end
        total++;
        if (ends != 1 || a_h !== 7'd1) begin
            bad++; $display("FAIL first_cycle_end got ends=%0d h=%0d want 1 1", ends, a_h);
        end
    endtask

    task automatic test_long_cycle();
        int n = 0;
        int phi_hi = 0;
        int vb;
        while (!(mh[0] == 64 && mt[0] == 0) && n < 1200) begin
            step(); n++;
        end
        total++;
        if (n >= 1200) begin
            bad++; $display("FAIL long_reach timeout got h=%0d want 64", a_h);
        end
        vb = mv[0];
        for (int k = 0; k < 16; k++) begin
            total++;
            if (a_sig !== exp_a(mt[0], mh[0], mv[0]) || a_h !== 7'(mh[0])) begin
                bad++; $display("FAIL long_tick t=%0d got=%h h=%0d want=%h h=%0d", mt[0], a_sig, a_h, exp_a(mt[0], mh[0], mv[0]), mh[0]);
            end
            if (a_phi0) phi_hi++;
            if (k >= 14) begin
                total++;
                if (a_q3 !== 1'b0 || a_ras !== 1'b0) begin
                    bad++; $display("FAIL long_q3_tail t=%0d got q3=%b ras_n=%b want 0 0", k, a_q3, a_ras);
                end
            end
            step();
        end
        total++;
        if (phi_hi != 9) begin
            bad++; $display("FAIL long_phi_width got=%0d want=9", phi_hi);
        end
        total++;
        if (a_h !== 7'd0 || a_v !== 9'(vb + 1) || a_phi0 !== 1'b0 || a_long !== 1'b0) begin
            bad++; $display("FAIL long_wrap got h=%0d v=%0d phi=%b want 0 %0d 0", a_h, a_v, a_phi0, vb + 1);
        end
    endtask

    task automatic test_line_invariant();
        for (int k = 0; k < 64 * 14 + 16; k++) begin
            total++;
            if (a_sig !== exp_a(mt[0], mh[0], mv[0]) || a_h !== 7'(mh[0]) || a_v !== 9'(mv[0])) begin
                bad++; $display("FAIL line_tick h=%0d t=%0d got=%h h=%0d v=%0d want=%h", mh[0], mt[0], a_sig, a_h, a_v, exp_a(mt[0], mh[0], mv[0]));
            end
            total++;
            if (!a_cas && (a_ras || a_ax)) begin
                bad++; $display("FAIL cas_invariant h=%0d t=%0d got ras_n=%b ax=%b want 0 0", mh[0], mt[0], a_ras, a_ax);
            end
            step();
        end
    endtask

    task automatic test_frame_b();
        int n = 0;
        int vbl_lines = 0;
        int vs_lines = 0;
        while (!(mv[1] == 0 && mh[1] == 0 && mt[1] == 0) && n < 10000) begin
            step(); n++;
        end
        total++;
        if (n >= 10000) begin
            bad++; $display("FAIL frame_sync timeout got v=%0d want 0", b_v);
        end
        for (int k = 0; k < 262 * 30; k++) begin
            step();
            total++;
            if (b_h !== 7'(mh[1]) || b_v !== 9'(mv[1])) begin
                bad++; $display("FAIL frame_count got h=%0d v=%0d want %0d %0d", b_h, b_v, mh[1], mv[1]);
            end
            if (mh[1] == 0 && mt[1] == 0) begin
                total++;
                if (b_vbl !== (mv[1] >= 192) || b_vs !== (mv[1] >= 224 && mv[1] <= 227)) begin
                    bad++; $display("FAIL frame_blank v=%0d got vbl=%b vs=%b", mv[1], b_vbl, b_vs);
                end
                if (b_vbl) vbl_lines++;
                if (b_vs) vs_lines++;
            end
        end
        total++;
        if (b_h !== 7'd0 || b_v !== 9'd0 || vbl_lines != 70 || vs_lines != 4) begin
            bad++; $display("FAIL frame_totals got h=%0d v=%0d vbl=%0d vs=%0d want 0 0 70 4", b_h, b_v, vbl_lines, vs_lines);
        end
    endtask

    task automatic test_pal_wrap();
        int n = 0;
        while (!(mv[2] == 311 && mh[2] == 1 && mt[2] == 15) && n < 12000) begin
            step(); n++;
        end
        total++;
        if (c_v !== 9'd311 || c_h !== 7'd1 || c_end !== 1'b1) begin
            bad++; $display("FAIL pal_last got v=%0d h=%0d end=%b want 311 1 1", c_v, c_h, c_end);
        end
        step();
        total++;
        if (c_v !== 9'd0 || c_h !== 7'd0 || c_vbl !== 1'b0) begin
            bad++; $display("FAIL pal_wrap got v=%0d h=%0d vbl=%b want 0 0 0", c_v, c_h, c_vbl);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        while (!(mt[0] == 11 && mh[0] != 0) && n < 2000) begin
            step(); n++;
        end
        total++;
        if (a_cas !== 1'b0 || a_ras !== 1'b0) begin
            bad++; $display("FAIL pre_reset_strobes got cas_n=%b ras_n=%b want 0 0", a_cas, a_ras);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (a_cas !== 1'b1 || a_ras !== 1'b1 || a_h !== 7'd0 || a_v !== 9'd0) begin
            bad++; $display("FAIL async_reset got cas_n=%b ras_n=%b h=%0d v=%0d want 1 1 0 0", a_cas, a_ras, a_h, a_v);
        end
        total++;
        if (a_sig !== 12'h7C8) begin
            bad++; $display("FAIL async_reset_outputs got=%h want=7c8", a_sig);
        end
        models_reset();
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 14; k++) begin
            step();
            total++;
            if (a_sig !== exp_a(mt[0], mh[0], mv[0])) begin
                bad++; $display("FAIL restart tick=%0d got=%h want=%h", mt[0], a_sig, exp_a(mt[0], mh[0], mv[0]));
            end
        end
        total++;
        if (a_h !== 7'd1 || a_v !== 9'd0) begin
            bad++; $display("FAIL restart_count got h=%0d v=%0d want 1 0", a_h, a_v);
        end
    endtask

    initial begin
        test_reset();
        test_first_cycle();
        test_long_cycle();
        test_line_invariant();
        test_frame_b();
        test_pal_wrap();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
